iob_resp: RTL and testbench
===========================

# iob_resp

Responder (target) side of the Mac SE PDS 68000-style I/O bus, clocked by C16M. It decodes master cycles (nAS/RnW/nUDS/nLDS), serves a bank of eight 16-bit registers with programmable wait states, and terminates each cycle with nDTACK or nBERR. It is the counterpart of the I/O bus master, used both as an on-card peripheral window and as the bus model in IOB-side benches.

## Interface
- BASE, 12'hEF0, A[23:12] match value for the register window.
- WAIT_CYC, 3, C16M cycles between decode and nDTACK assertion (0–15).
- TIMEOUT, 255, C16M cycles from synced nAS fall to nBERR if the cycle cannot complete (≤255).
- ID, 16'h5345, read value of register 7.
- C16M  in  1  sole clock; all state on rising edge.
- nRES  in  1  reset, asynchronous, active-low.
- A  in  23  address A[23:1].
- nAS, nUDS, nLDS, RnW  in  1 each  master strobes, asynchronous to C16M.
- E, nVMA  in  1 each  6800 E clock and valid-memory-address strobe.
- D_in  in  16  write data from bus.
- D_out  out  16  read data; valid while DOE=1.
- DOE  out  1  data bus output enable.
- nDTACK, nVPA, nBERR  out  1 each  cycle termination strobes (pad open-drain at top level).

## Operation
- nAS, nUDS, nLDS, E each pass a 2-FF synchronizer; A, RnW, D_in are sampled only when the synced strobes say they are stable.
- States: IDLE, DECODE, WAIT, ACK, ERR, HOLD (plus VWAIT, VACK with macro).
- IDLE → DECODE on synced nAS low; A and RnW captured into regs this cycle.
- DECODE: A[23:12]≠BASE → IDLE silently (not our cycle). Hit with A[11]=0 → WAIT, counter=WAIT_CYC. Hit with A[11]=1 → VWAIT (macro) else ERR.
- WAIT: counter decrements; at 0 and synced DS (either) low → ACK. Writes require DS low before leaving WAIT; reads with DS high also wait.
- ACK: nDTACK=0; read drives D_out=reg[A[3:1]], DOE=1; write commits D_in bytes per lane (nUDS→[15:8], nLDS→[7:0]) exactly once on ACK entry. Reg 7 read-only (writes ignored). → HOLD.
- HOLD: outputs held until synced nAS high, then all strobes/DOE released next cycle → IDLE.
- ERR: nBERR=0 until synced nAS high → IDLE.
- Timeout counter runs from DECODE; expiry in WAIT/VWAIT → ERR.
- Synced nAS high in DECODE/WAIT/VWAIT (aborted cycle) → IDLE, no write, no strobe.
- Reset values: nDTACK=1, nVPA=1, nBERR=1, DOE=0, D_out=0, regs 0–6=0, state IDLE. Reset mid-cycle deasserts everything immediately.

## Timing
- nAS fall to DECODE: 2–3 C16M (synchronizer).
- DECODE to nDTACK low: WAIT_CYC+1 cycles when DS already low.
- nAS rise to strobe release: 3 cycles max.
- Back-to-back cycles: a new nAS fall is not accepted until IDLE is re-entered.

## Configuration
- IOBR_VPA_EN defined: A[11]=1 hits use the 6800 synchronous path. VWAIT asserts nVPA=0; waits for nVMA low, then synced E falling edge → VACK: read data driven/write committed on that edge, → HOLD (nVPA held until nAS rises).
- Undefined: VWAIT/VACK not built; A[11]=1 hits → ERR (nBERR).

## Structure
- Shared package iob_pkg: state enum, register count (8), ID register index (7), BASE default.
- One sub-module: iob_sync (parametric-width 2-FF synchronizer with async nRES clear, idle-high reset value).

## Test plan
- Write 16'hA55A to $EF0002 (both DS), WAIT_CYC=3 → nDTACK low 4 cycles after DECODE; readback 16'hA55A with DOE=1.
- Byte write 8'h77 with nLDS only to reg 1 (was 16'h1234) → reg 1 = 16'h1277.
- Read $EF000E → D_out=16'h5345; write to it → value unchanged.
- Access $EF0800, macro off → nBERR low, released ≤3 cycles after nAS rise; macro on, nVMA low → nVPA low, data transfers on E falling edge.
- Write with DS never asserted → nBERR at TIMEOUT cycles; nAS abort mid-WAIT → no strobe, no register change.
- nRES pulsed during ACK → nDTACK/DOE high asynchronously; regs cleared; next cycle serviced normally.

Source files
------------

// File: rtl/iob_pkg.sv
// iob_pkg: shared types and constants for the I/O bus responder.
//   state_e    - responder FSM states (6800 states only with IOBR_VPA_EN)
//   NREG       - number of 16-bit registers in the window
//   ID_IDX     - index of the read-only ID register
//   BASE_DEF   - default A[23:12] match value
//   lane_merge - byte-lane write merge driven by active-low data strobes
package iob_pkg;
  localparam int NREG = 8;
  localparam int ID_IDX = 7;
  localparam logic [11:0] BASE_DEF = 12'hEF0;
`ifdef IOBR_VPA_EN
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_ACK, S_ERR, S_HOLD, S_VWAIT, S_VACK} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_ACK, S_ERR, S_HOLD} state_e;
`endif
  function automatic logic [15:0] lane_merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                             input logic nuds, input logic nlds);
    return {nuds ? old_v[15:8] : new_v[15:8], nlds ? old_v[7:0] : new_v[7:0]};
  endfunction
endpackage

// File: rtl/iob_sync.sv
// iob_sync: W-bit 2-FF synchronizer, asynchronously cleared to all-ones (idle-high strobes).
//   C16M - clock, nRES - async active-low clear
//   d_i  - asynchronous inputs, q_o - synchronized outputs
module iob_sync #(
  parameter int W = 1
) (
  input  logic         C16M,
  input  logic         nRES,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] ff1_q, ff2_q;
  always_ff @(posedge C16M or negedge nRES)
    if (!nRES) begin
      ff1_q <= '1;
      ff2_q <= '1;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  assign q_o = ff2_q;
endmodule

// File: rtl/iob_resp.sv
// iob_resp: 68000-style I/O bus responder serving eight 16-bit registers with wait states.
//   Clock/reset : C16M, nRES (async active-low)
//   Bus in      : A[23:1], nAS, nUDS, nLDS, RnW, D_in[15:0], E, nVMA
//   Bus out     : D_out[15:0], DOE, nDTACK, nVPA, nBERR (all registered, idle high / DOE low)
//   Option      : IOBR_VPA_EN builds the 6800 synchronous (nVPA/E) path for A[11]=1 hits;
//                 without it such hits terminate with nBERR.
module iob_resp
  import iob_pkg::*;
#(
  parameter logic [11:0] BASE     = BASE_DEF,
  parameter int          WAIT_CYC = 3,
  parameter int          TIMEOUT  = 255,
  parameter logic [15:0] ID       = 16'h5345
) (
  input  logic        C16M,
  input  logic        nRES,
  input  logic [23:1] A,
  input  logic        nAS,
  input  logic        nUDS,
  input  logic        nLDS,
  input  logic        RnW,
  input  logic        E,
  input  logic        nVMA,
  input  logic [15:0] D_in,
  output logic [15:0] D_out,
  output logic        DOE,
  output logic        nDTACK,
  output logic        nVPA,
  output logic        nBERR
);
  localparam logic [3:0] WLOAD = 4'(WAIT_CYC);
  // Loaded on DECODE entry so nBERR lands TIMEOUT cycles after the synced nAS fall.
  localparam logic [7:0] TLOAD = 8'(TIMEOUT - 2);

  logic [3:0] s;
  logic as_s, uds_s, lds_s, e_s;
  iob_sync #(.W(4)) u_sync (.C16M, .nRES, .d_i({nAS, nUDS, nLDS, E}), .q_o(s));
  assign {as_s, uds_s, lds_s, e_s} = s;

  state_e state_q, state_d;
  logic [23:1] a_q, a_d;
  logic rnw_q, rnw_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [15:0] regs_q [NREG];
  logic [15:0] regs_d [NREG];
  logic [15:0] dout_q, dout_d;
  logic doe_q, doe_d, dtack_q, dtack_d, berr_q, berr_d, vpa_q, vpa_d;
  logic ds_low, hit, xfer;
  logic [2:0] idx;
  logic [15:0] rd;

  assign ds_low = !(uds_s && lds_s);
  assign hit = a_q[23:12] == BASE;
  assign idx = a_q[3:1];
  assign rd = idx == 3'(ID_IDX) ? ID : regs_q[idx];

`ifdef IOBR_VPA_EN
  logic e_q;
  always_ff @(posedge C16M or negedge nRES)
    if (!nRES) e_q <= 1'b1;
    else e_q <= e_s;
  logic unused_sig;
  assign unused_sig = ^a_q[10:4];
`else
  logic unused_sig;
  assign unused_sig = ^{a_q[10:4], e_s, nVMA};
`endif

  always_comb begin
    state_d = state_q;
    a_d = a_q;
    rnw_d = rnw_q;
    wcnt_d = wcnt_q;
    tcnt_d = tcnt_q;
    regs_d = regs_q;
    case (state_q)
      S_IDLE:
        if (!as_s) begin
          state_d = S_DECODE;
          a_d = A;
          rnw_d = RnW;
          tcnt_d = TLOAD;
        end
      S_DECODE: begin
        wcnt_d = WLOAD;
        tcnt_d = tcnt_q - 8'd1;
        if (as_s || !hit) state_d = S_IDLE;
        else if (!a_q[11]) state_d = S_WAIT;
`ifdef IOBR_VPA_EN
        else state_d = S_VWAIT;
`else
        else state_d = S_ERR;
`endif
      end
      S_WAIT: begin
        wcnt_d = wcnt_q == 4'd0 ? 4'd0 : wcnt_q - 4'd1;
        tcnt_d = tcnt_q - 8'd1;
        if (as_s) state_d = S_IDLE;
        else if (tcnt_q == 8'd0) state_d = S_ERR;
        else if (wcnt_q <= 4'd1 && ds_low) state_d = S_ACK;
      end
`ifdef IOBR_VPA_EN
      S_VWAIT: begin
        tcnt_d = tcnt_q - 8'd1;
        // Transfer on the synced E falling edge of a valid 6800 cycle.
        if (as_s) state_d = S_IDLE;
        else if (tcnt_q == 8'd0) state_d = S_ERR;
        else if (!nVMA && e_q && !e_s && ds_low) state_d = S_VACK;
      end
      S_VACK: state_d = S_HOLD;
`endif
      S_ACK: state_d = S_HOLD;
      S_HOLD, S_ERR: if (as_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef IOBR_VPA_EN
    xfer = state_d == S_ACK || state_d == S_VACK;
    vpa_d = !(state_d == S_VWAIT || state_d == S_VACK || (state_d == S_HOLD && !vpa_q));
`else
    xfer = state_d == S_ACK;
    vpa_d = 1'b1;
`endif
    // Entry into ACK/VACK happens exactly once per cycle, so the write commits once.
    if (xfer && !rnw_q && idx != 3'(ID_IDX)) regs_d[idx] = lane_merge(regs_q[idx], D_in, uds_s, lds_s);
    dtack_d = !(state_d == S_ACK || (state_d == S_HOLD && !dtack_q));
    berr_d = state_d != S_ERR;
    doe_d = xfer ? rnw_q : state_d == S_HOLD && doe_q;
    dout_d = xfer && rnw_q ? rd : state_d == S_HOLD ? dout_q : '0;
  end

  always_ff @(posedge C16M or negedge nRES)
    if (!nRES) begin
      state_q <= S_IDLE;
      a_q <= '0;
      rnw_q <= 1'b1;
      wcnt_q <= '0;
      tcnt_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      dout_q <= '0;
      doe_q <= 1'b0;
      dtack_q <= 1'b1;
      berr_q <= 1'b1;
      vpa_q <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      rnw_q <= rnw_d;
      wcnt_q <= wcnt_d;
      tcnt_q <= tcnt_d;
      regs_q <= regs_d;
      dout_q <= dout_d;
      doe_q <= doe_d;
      dtack_q <= dtack_d;
      berr_q <= berr_d;
      vpa_q <= vpa_d;
    end

  assign D_out = dout_q;
  assign DOE = doe_q;
  assign nDTACK = dtack_q;
  assign nBERR = berr_q;
  assign nVPA = vpa_q;
endmodule

// File: tb/tb_iob_resp.sv
// tb_iob_resp: directed bench for iob_resp with a scoreboard-driven termination monitor.
module tb_iob_resp;
  logic C16M = 1'b0, nRES = 1'b1;
  logic [23:1] A = '0;
  logic nAS = 1'b1, nUDS = 1'b1, nLDS = 1'b1, RnW = 1'b1, E = 1'b1, nVMA = 1'b1;
  logic [15:0] D_in = '0;
  logic [15:0] D_out;
  logic DOE, nDTACK, nVPA, nBERR;
  int tests = 0, fails = 0;
  typedef struct {bit berr; bit rd; logic [15:0] data;} exp_t;
  exp_t sb[$];
  logic pd = 1'b1, pb = 1'b1;

  iob_resp dut (.C16M(C16M), .nRES(nRES), .A(A), .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS), .RnW(RnW),
                .E(E), .nVMA(nVMA), .D_in(D_in), .D_out(D_out), .DOE(DOE), .nDTACK(nDTACK),
                .nVPA(nVPA), .nBERR(nBERR));

  always #5 C16M = ~C16M;
  initial forever begin
    repeat (6) @(negedge C16M);
    E = ~E;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge C16M);
    if ((!nDTACK && pd) || (!nBERR && pb)) begin
      if (sb.size() == 0) chk("unexpected_strobe", {nDTACK, nBERR}, 2'b11);
      else begin
        e = sb.pop_front();
        chk("sb_kind", {nDTACK, nBERR}, e.berr ? 2'b10 : 2'b01);
        chk("sb_doe", DOE, e.rd && !e.berr);
        if (e.rd && !e.berr) chk("sb_data", D_out, e.data);
      end
    end
    pd = nDTACK;
    pb = nBERR;
  end

  task automatic start(input logic [23:0] ad, input logic rnw, input logic nu, input logic nl,
                       input logic [15:0] wd);
    @(negedge C16M);
    A = ad[23:1];
    RnW = rnw;
    D_in = wd;
    nAS = 1'b0;
    nUDS = nu;
    nLDS = nl;
  endtask

  task automatic wait_term(output int lat);
    lat = 0;
    do begin
      @(posedge C16M);
      #1 lat++;
    end while (nDTACK && nBERR && lat < 400);
  endtask

  task automatic finish(input string nm);
    int rel;
    rel = 0;
    @(negedge C16M);
    nAS = 1'b1;
    nUDS = 1'b1;
    nLDS = 1'b1;
    RnW = 1'b1;
    do begin
      @(posedge C16M);
      #1 rel++;
    end while ((!nDTACK || !nBERR || !nVPA || DOE) && rel < 20);
    chk({nm, "_release"}, rel <= 3, 1);
    repeat (2) @(negedge C16M);
  endtask

  task automatic wr(input logic [23:0] ad, input logic nu, input logic nl, input logic [15:0] wd,
                    input string nm);
    int lat;
    sb.push_back('{berr: 1'b0, rd: 1'b0, data: 16'h0});
    start(ad, 1'b0, nu, nl, wd);
    wait_term(lat);
    chk({nm, "_lat"}, lat, 7);
    finish(nm);
  endtask

  task automatic rd(input logic [23:0] ad, input logic [15:0] ex, input string nm);
    int lat;
    sb.push_back('{berr: 1'b0, rd: 1'b1, data: ex});
    start(ad, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_term(lat);
    chk({nm, "_lat"}, lat, 7);
    finish(nm);
  endtask

  task automatic quiet(input logic [23:0] ad, input logic rnw, input logic nu, input logic nl,
                       input string nm);
    bit seen;
    seen = 1'b0;
    start(ad, rnw, nu, nl, 16'hBEEF);
    repeat (8) begin
      @(posedge C16M);
      #1 if (!nDTACK || !nBERR || !nVPA || DOE) seen = 1'b1;
    end
    chk({nm, "_quiet"}, seen, 0);
    finish(nm);
  endtask

  initial begin
    int lat;
    #1 nRES = 1'b0;
    #1;
    chk("rst_dtack", nDTACK, 1);
    chk("rst_berr", nBERR, 1);
    chk("rst_vpa", nVPA, 1);
    chk("rst_doe", DOE, 0);
    chk("rst_dout", D_out, 0);
    repeat (3) @(negedge C16M);
    nRES = 1'b1;
    repeat (2) @(negedge C16M);
    wr(24'hEF0002, 1'b0, 1'b0, 16'hA55A, "wr_a55a");
    rd(24'hEF0002, 16'hA55A, "rd_a55a");
    wr(24'hEF0002, 1'b0, 1'b0, 16'h1234, "wr_1234");
    wr(24'hEF0002, 1'b1, 1'b0, 16'hFF77, "wr_byte_lo");
    rd(24'hEF0002, 16'h1277, "rd_byte_lo");
    wr(24'hEF000C, 1'b0, 1'b1, 16'hBE99, "wr_byte_hi");
    rd(24'hEF000C, 16'hBE00, "rd_byte_hi");
    wr(24'hEF0000, 1'b0, 1'b0, 16'h0F0F, "wr_reg0");
    rd(24'hEF0000, 16'h0F0F, "rd_reg0");
    rd(24'hEF000E, 16'h5345, "rd_id");
    wr(24'hEF000E, 1'b0, 1'b0, 16'hFFFF, "wr_id");
    rd(24'hEF000E, 16'h5345, "rd_id_again");
    quiet(24'h100004, 1'b1, 1'b0, 1'b0, "miss");
`ifdef IOBR_VPA_EN
    nVMA = 1'b0;
    start(24'hEF0802, 1'b1, 1'b0, 1'b0, 16'h0);
    lat = 0;
    do begin
      @(posedge C16M);
      #1 lat++;
    end while (nVPA && lat < 50);
    chk("vpa_lat", lat, 4);
    lat = 0;
    while (!DOE && lat < 60) begin
      @(posedge C16M);
      #1 lat++;
    end
    chk("vpa_doe", DOE, 1);
    chk("vpa_data", D_out, 16'h1277);
    chk("vpa_no_dtack", nDTACK, 1);
    finish("vpa_rd");
    start(24'hEF080A, 1'b0, 1'b0, 1'b0, 16'h5A5A);
    repeat (40) @(posedge C16M);
    #1 chk("vpa_wr_vpa", nVPA, 0);
    finish("vpa_wr");
    nVMA = 1'b1;
    rd(24'hEF000A, 16'h5A5A, "rd_vpa_wr");
`else
    sb.push_back('{berr: 1'b1, rd: 1'b0, data: 16'h0});
    start(24'hEF0800, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_term(lat);
    chk("a11_berr_lat", lat, 4);
    finish("a11_berr");
`endif
    wr(24'hEF0004, 1'b0, 1'b0, 16'h1111, "wr_reg2");
    sb.push_back('{berr: 1'b1, rd: 1'b0, data: 16'h0});
    start(24'hEF0004, 1'b0, 1'b1, 1'b1, 16'hDEAD);
    wait_term(lat);
    chk("timeout_lat", lat, 257);
    finish("timeout");
    rd(24'hEF0004, 16'h1111, "rd_after_timeout");
    quiet(24'hEF0004, 1'b0, 1'b1, 1'b1, "abort");
    rd(24'hEF0004, 16'h1111, "rd_after_abort");
    wr(24'hEF0006, 1'b0, 1'b0, 16'h3333, "wr_reg3");
    sb.push_back('{berr: 1'b0, rd: 1'b1, data: 16'h3333});
    start(24'hEF0006, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_term(lat);
    chk("rst_ack_lat", lat, 7);
    @(negedge C16M);
    #1 nRES = 1'b0;
    #1;
    chk("midrst_dtack", nDTACK, 1);
    chk("midrst_doe", DOE, 0);
    chk("midrst_dout", D_out, 0);
    nAS = 1'b1;
    nUDS = 1'b1;
    nLDS = 1'b1;
    @(negedge C16M);
    nRES = 1'b1;
    repeat (3) @(negedge C16M);
    rd(24'hEF0006, 16'h0000, "rd_reg3_cleared");
    rd(24'hEF0002, 16'h0000, "rd_reg1_cleared");
    wr(24'hEF0008, 1'b0, 1'b0, 16'hC0DE, "wr_post_rst");
    rd(24'hEF0008, 16'hC0DE, "rd_post_rst");
    repeat (2) @(negedge C16M);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
